// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Each transaction is IDLE (grant) -> EXEC (one ALU cycle) -> RESP (held response).
module alu_share_arbiter #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [3:0]        req0_operation,
    input  logic [4:0]        req0_shamt,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [3:0]        req1_operation,
    input  logic [4:0]        req1_shamt,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [3:0]        alu_operation,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic              grant, grant_nxt, last_grant;
    logic              req_fire, rsp_fire;
    logic [DATA_W-1:0] op1_p0, op2_p0;
    logic [3:0]        operation_p0;
    logic [4:0]        shamt_p0;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        grant_nxt = req_valid[1];
        if (req_valid == 2'b11)
            grant_nxt = ~last_grant;
    end

    assign req_fire = (state == IDLE) && (req_valid != 2'b00);
    assign rsp_fire = (state == RESP) && rsp_ready[grant];

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 2'b00;
        alu_operation = 4'h0;
        busy          = 1'b0;
        case (state)
            IDLE: if (req_fire) req_ready[grant_nxt] = 1'b1;
            EXEC: begin
                alu_operation = operation_p0;
                busy          = 1'b1;
            end
            RESP:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign alu_op1   = op1_p0;
    assign alu_op2   = op2_p0;
    assign alu_shamt = shamt_p0;

    // Stage p0: operand capture on request handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= 1'b0;
            op1_p0       <= '0;
            op2_p0       <= '0;
            operation_p0 <= 4'h0;
            shamt_p0     <= 5'd0;
        end else if (req_fire) begin
            grant        <= grant_nxt;
            op1_p0       <= grant_nxt ? req1_op1       : req0_op1;
            op2_p0       <= grant_nxt ? req1_op2       : req0_op2;
            operation_p0 <= grant_nxt ? req1_operation : req0_operation;
            shamt_p0     <= grant_nxt ? req1_shamt     : req0_shamt;
        end
    end

    // Stage p1: ALU outputs captured at the end of EXEC and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 2'b00;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            last_grant   <= 1'b1;
            op_count     <= '0;
        end else if (state == EXEC) begin
            rsp_valid        <= 2'b00;
            rsp_valid[grant] <= 1'b1;
            rsp_result       <= alu_result;
            rsp_zero         <= alu_zero;
            rsp_overflow     <= alu_overflow;
        end else if (rsp_fire) begin
            rsp_valid  <= 2'b00;
            last_grant <= grant;
            op_count   <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter with a small behavioural ALU.
// A second instance with CNT_W=2 shares all inputs to exercise counter wrap.
module tb_alu_share_arbiter;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid, req_ready, req_ready2;
    logic [DATA_W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]        req0_operation, req1_operation;
    logic [4:0]        req0_shamt, req1_shamt;
    logic [DATA_W-1:0] alu_op1, alu_op2, alu_result;
    logic [3:0]        alu_operation;
    logic [4:0]        alu_shamt;
    logic              alu_zero, alu_overflow;
    logic [1:0]        rsp_valid, rsp_ready, rsp_valid2;
    logic [DATA_W-1:0] rsp_result, rsp_result2;
    logic              rsp_zero, rsp_overflow, busy;
    logic              rsp_zero2, rsp_overflow2, busy2;
    logic [15:0]       op_count;
    logic [1:0]        op_count2;
    logic [DATA_W-1:0] alu_op1_2, alu_op2_2;
    logic [3:0]        alu_operation2;
    logic [4:0]        alu_shamt2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_operation(req0_operation), .req0_shamt(req0_shamt),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_operation(req1_operation), .req1_shamt(req1_shamt),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .busy(busy), .op_count(op_count)
    );

    alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_operation(req0_operation), .req0_shamt(req0_shamt),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_operation(req1_operation), .req1_shamt(req1_shamt),
        .alu_op1(alu_op1_2), .alu_op2(alu_op2_2), .alu_operation(alu_operation2), .alu_shamt(alu_shamt2),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
        .rsp_zero(rsp_zero2), .rsp_overflow(rsp_overflow2), .busy(busy2), .op_count(op_count2)
    );

    // Behavioural ALU: 4 = add, 7 = sub, 8 = shift op2 left by shamt
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_operation)
            4'h4: begin
                alu_result   = alu_op1 + alu_op2;
                alu_overflow = (alu_op1[63] == alu_op2[63]) && (alu_result[63] != alu_op1[63]);
            end
            4'h7: begin
                alu_result   = alu_op1 - alu_op2;
                alu_overflow = (alu_op1[63] != alu_op2[63]) && (alu_result[63] != alu_op1[63]);
            end
            4'h8:    alu_result = alu_op2 << alu_shamt;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req0_op1 = '0; req0_op2 = '0; req0_operation = 4'h0; req0_shamt = 5'd0;
        req1_op1 = '0; req1_op2 = '0; req1_operation = 4'h0; req1_shamt = 5'd0;
        step(); step();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_count", op_count, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_operation", alu_operation, 4'h0);
        rst = 1'b0;

        // single add from requester 0
        req_valid = 2'b01; req0_op1 = 64'd5; req0_op2 = 64'd7; req0_operation = 4'h4;
        #1;
        chk("add_req_ready", req_ready, 2'b01);
        chk("add_idle_noop", alu_operation, 4'h0);
        step(); req_valid = 2'b00; #1;
        chk("add_exec_operation", alu_operation, 4'h4);
        chk("add_exec_busy", busy, 1'b1);
        chk("add_exec_rsp_valid", rsp_valid, 2'b00);
        step();
        chk("add_rsp_valid", rsp_valid, 2'b01);
        chk("add_rsp_result", rsp_result, 64'd12);
        chk("add_rsp_zero", rsp_zero, 1'b0);
        chk("add_rsp_ovf", rsp_overflow, 1'b0);
        chk("add_resp_noop", alu_operation, 4'h0);
        rsp_ready = 2'b01;
        step();
        chk("add_op_count", op_count, 1);
        chk("add_done_rsp_valid", rsp_valid, 2'b00);
        chk("add_done_busy", busy, 1'b0);

        // subtract to zero from requester 1
        req_valid = 2'b10; req1_op1 = 64'd3; req1_op2 = 64'd3; req1_operation = 4'h7; rsp_ready = 2'b10;
        #1;
        chk("sub_req_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        step();
        chk("sub_rsp_valid", rsp_valid, 2'b10);
        chk("sub_rsp_result", rsp_result, 64'd0);
        chk("sub_rsp_zero", rsp_zero, 1'b1);
        step();
        chk("sub_op_count", op_count, 2);

        // tie round-robin after reset, also wraps the CNT_W=2 counter
        rst = 1'b1; step(); rst = 1'b0;
        req0_op1 = 64'd10; req0_op2 = 64'd20; req0_operation = 4'h4;
        req1_op1 = 64'd100; req1_op2 = 64'd1; req1_operation = 4'h7;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_req_ready_%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            step(); step();
            chk($sformatf("rr_rsp_valid_%0d", k), rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_rsp_result_%0d", k), rsp_result, (k % 2 == 0) ? 64'd30 : 64'd99);
            step();
            chk($sformatf("rr_wrap_count_%0d", k), op_count2, (k + 1) % 4);
        end
        req_valid = 2'b00;
        chk("rr_op_count", op_count, 4);
        chk("wrap_op_count", op_count2, 0);

        // backpressure: requester 1 waits while response 0 is held
        req0_op1 = 64'd0; req0_op2 = 64'd1; req0_shamt = 5'd4; req0_operation = 4'h8;
        req1_op1 = 64'd9; req1_op2 = 64'd4;
        req_valid = 2'b11; rsp_ready = 2'b00;
        #1;
        chk("bp_req_ready", req_ready, 2'b01);
        step();
        chk("bp_exec_req_ready", req_ready, 2'b00);
        step();
        rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_hold_result_%0d", k), rsp_result, 64'd16);
            chk($sformatf("bp_hold_valid_%0d", k), rsp_valid, 2'b01);
            chk($sformatf("bp_hold_ready_%0d", k), req_ready, 2'b00);
            step();
        end
        rsp_ready = 2'b01;
        step();
        chk("bp_count", op_count, 5);
        chk("bp_req1_grant", req_ready, 2'b10);

        // reset during EXEC discards the request
        rsp_ready = 2'b00;
        step();
        chk("rexec_busy", busy, 1'b1);
        rst = 1'b1; req_valid = 2'b00;
        step();
        rst = 1'b0; rsp_ready = 2'b11;
        chk("rexec_rsp_valid", rsp_valid, 2'b00);
        chk("rexec_busy_after", busy, 1'b0);
        chk("rexec_op_count", op_count, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rexec_no_rsp_%0d", k), {busy, rsp_valid}, 3'b000);
        end

        // signed overflow, and requester 0 wins the first tie after reset
        req0_op1 = 64'h7FFF_FFFF_FFFF_FFFF; req0_op2 = 64'd1; req0_operation = 4'h4;
        req_valid = 2'b11;
        #1;
        chk("ovf_tie_grant", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        step();
        chk("ovf_rsp_result", rsp_result, 64'h8000_0000_0000_0000);
        chk("ovf_rsp_ovf", rsp_overflow, 1'b1);
        step();
        chk("ovf_op_count", op_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single ALU between two requesters, for example the EX-stage issue port and a multi-cycle helper such as the branch/compare unit. The arbiter arbitrates round-robin and registers the winning request's operands. It drives the ALU for exactly one cycle, then captures the ALU result, zero and overflow flags into a held response. Requests and responses both use valid/ready handshakes. All state is synchronous to clk.

Parameters:
DATA_W, 64, width of operands and result (matches ALU Op1/Op2/EXE_Result)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester request accept; one-hot or zero
req0_op1  input  DATA_W  requester 0 Op1
req0_op2  input  DATA_W  requester 0 Op2
req0_operation  input  4  requester 0 ALU operation code
req0_shamt  input  5  requester 0 shift amount
req1_op1 / req1_op2 / req1_operation / req1_shamt  input  DATA_W/DATA_W/4/5  requester 1 equivalents
alu_op1  output  DATA_W  to ALU Op1
alu_op2  output  DATA_W  to ALU Op2
alu_operation  output  4  to ALU operation
alu_shamt  output  5  to ALU shamt
alu_result  input  DATA_W  from ALU EXE_Result
alu_zero  input  1  from ALU EXE_Zero
alu_overflow  input  1  from ALU Overflow
rsp_valid  output  2  per-requester response valid; one-hot or zero
rsp_ready  input  2  per-requester response accept
rsp_result  output  DATA_W  captured result (shared bus)
rsp_zero  output  1  captured zero flag
rsp_overflow  output  1  captured overflow flag
busy  output  1  high when FSM not in IDLE
op_count  output  CNT_W  completed transactions, wraps modulo 2^CNT_W

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset puts the FSM in IDLE.
- Reset values:
  - req_ready=0, rsp_valid=0, busy=0, op_count=0.
  - rsp_result=0, rsp_zero=0, rsp_overflow=0.
  - Operand registers=0; grant register=0; last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Else grant g: the sole valid requester, or on a tie the requester != last_grant.
  - req_ready[g]=1 combinationally in the same cycle; the other bit stays 0. req_ready is never asserted outside IDLE.
  - On the handshake edge, latch g's op1/op2/operation/shamt into operand registers and go to EXEC.
- ALU drive:
  - alu_op1/alu_op2/alu_shamt always come from the operand registers.
  - alu_operation = registered operation in EXEC, 4'h0 (no-op) otherwise. The ALU therefore only evaluates a real operation during EXEC.
- EXEC: exactly one cycle. At the end of the cycle, capture alu_result/alu_zero/alu_overflow into rsp_* registers and go to RESP. No arithmetic or flag modification inside the arbiter; the ALU flags pass through unchanged.
- RESP:
  - rsp_valid[g]=1 (registered); rsp_* held stable.
  - On rsp_valid[g] && rsp_ready[g]: clear rsp_valid, set last_grant=g, increment op_count, return to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Latency: request handshake at cycle N, EXEC at N+1, rsp_valid high from N+2. Minimum 3 cycles per transaction; no overlap.
- Backpressure: rsp_ready low holds RESP indefinitely. New req_valid is neither accepted nor lost; requesters keep valid asserted.
- Requests must hold operands stable while valid and not ready. Dropping req_valid before the grant is legal and causes no transaction.
- busy=1 in EXEC and RESP.
- op_count wrap: all-ones + 1 → 0, no sticky flag.
- Reset mid-operation (EXEC or RESP): the in-flight transaction is discarded, no response is issued, and all registers return to reset values on that edge.
- rst has priority over every handshake in the same cycle.

Test Plan:
- Single add: req0 op1=5, op2=7, operation=4'h4 → req_ready=2'b01 same cycle; alu_operation=4'h4 only in EXEC; rsp_valid=2'b01 two cycles later; rsp_result=12, zero=0, overflow=0; op_count=1.
- Subtract-to-zero: req1 op1=3, op2=3, operation=4'h7 with rsp_ready=1 → rsp_valid=2'b10, rsp_result=0, rsp_zero=1.
- Tie and round-robin: after reset assert both req_valid continuously with rsp_ready=2'b11 → grants in order 0,1,0,1; each rsp on the matching bit; op_count=4 after 12 cycles.
- Backpressure: req0 shift-left op2=1, shamt=4, operation=4'h8; hold rsp_ready=0 for 5 cycles with req1 valid → rsp_result=16 stable, req_ready=0 throughout; req1 granted the cycle after the rsp0 handshake.
- Reset in EXEC: assert rst during EXEC → next cycle rsp_valid=0, busy=0, op_count unchanged at 0; no response ever issued for that request.
- Counter wrap: force 2^CNT_W transactions (or CNT_W=2 build, 4 transactions) → op_count returns to 0.
